// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands MSB slice first, CHUNK bits per clock.
// Optional two's-complement mode is enabled by defining SEQCMP_SIGNED_EN (adds the sgn port).
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SEQCMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [WIDTH-1:0] flip;

`ifdef SEQCMP_SIGNED_EN
  // Inverting the sign bit of both operands maps two's complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  assign flip = sgn ? SIGN_MASK : '0;
`else
  assign flip = '0;
`endif

  always_comb begin
    a_slice = a_q[int'(idx)*CHUNK +: CHUNK];
    b_slice = b_q[int'(idx)*CHUNK +: CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A ^ flip;
            b_q   <= B ^ flip;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            idx   <= TOP_IDX;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (a_slice != b_slice) begin
            gt    <= (a_slice > b_slice);
            lt    <= (a_slice < b_slice);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4); random and directed compares
// checked against an arithmetic reference model.
module tb_seq_magnitude_comparator;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sgn;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  int compared;
  int mismatched;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SEQCMP_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: numeric order from plain integer arithmetic, latency from the first differing slice.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       output int lat, output logic e, output logic g, output logic l);
    longint va;
    longint vb;
    va = s ? longint'($signed(a)) : longint'(a);
    vb = s ? longint'($signed(b)) : longint'(b);
    e = (va == vb);
    g = (va > vb);
    l = (va < vb);
    lat = NCHUNK + 1;
    for (int p = 0; p < NCHUNK; p++) begin
      int sh;
      sh = (NCHUNK - 1 - p) * CHUNK;
      if (((a >> sh) % (1 << CHUNK)) != ((b >> sh) % (1 << CHUNK))) begin
        lat = p + 2;
        break;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after the bound expires).
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, input bit inject);
    int   lat;
    int   k;
    logic e, g, l;
    logic s_eff;
`ifdef SEQCMP_SIGNED_EN
    s_eff = s;
`else
    s_eff = 1'b0;
`endif
    model(a, b, s_eff, lat, e, g, l);
    A = a; B = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
    sgn = ~s;
    k = 1;
    while (!done && k <= 20) begin
      checkOutput("busy_during_run", {31'd0, busy}, 32'd1);
      if (inject && k == 1) begin
        start = 1'b1; A = '0; B = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", k, lat);
      checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
      checkOutput("eq", {31'd0, eq}, {31'd0, e});
      checkOutput("gt", {31'd0, gt}, {31'd0, g});
      checkOutput("lt", {31'd0, lt}, {31'd0, l});
    end
  endtask

  task automatic checkAfterDone(input logic e, input logic g, input logic l);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("hold_eq", {31'd0, eq}, {31'd0, e});
    checkOutput("hold_gt", {31'd0, gt}, {31'd0, g});
    checkOutput("hold_lt", {31'd0, lt}, {31'd0, l});
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rs;
    compared = 0;
    mismatched = 0;
    start = 1'b0; A = '0; B = '0; sgn = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_flags", {29'd0, eq, gt, lt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands: full walk through all slices.
    applyStimulus(16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    checkAfterDone(1'b1, 1'b0, 1'b0);

    // Early termination on the MSB slice, unsigned then signed.
    applyStimulus(16'h8000, 16'h7FFF, 1'b0, 1'b0);
    checkAfterDone(1'b0, 1'b1, 1'b0);
`ifdef SEQCMP_SIGNED_EN
    applyStimulus(16'h8000, 16'h7FFF, 1'b1, 1'b0);
    checkAfterDone(1'b0, 1'b0, 1'b1);
`endif

    // LSB mismatch, then a back-to-back start in the done cycle.
    applyStimulus(16'h1234, 16'h1235, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    checkAfterDone(1'b0, 1'b1, 1'b0);

    // Start pulsed while busy must be ignored and yield only one done.
    applyStimulus(16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
    checkAfterDone(1'b1, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_extra_done", {30'd0, done, busy}, 32'd0);
    end

    // Reset in the middle of a compare.
    A = 16'hBEEF; B = 16'hBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_outputs", {28'd0, done, eq, gt, lt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_done_after_abort", {30'd0, done, busy}, 32'd0);
    end
    applyStimulus(16'h00F0, 16'h00E0, 1'b0, 1'b0);
    checkAfterDone(1'b0, 1'b1, 1'b0);

    // Randomized compares, biased so the first differing slice lands anywhere.
    for (int i = 0; i < 60; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = WIDTH'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      endcase
      rs = 1'($urandom);
      applyStimulus(ra, rb, rs, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
